// File: rtl/fire_fifo_param.sv
// Parametrised first-word-fall-through FIFO for fire (spike) tags, with occupancy
// count, almost-full, sticky overflow/underflow flags and a selectable overflow policy.
module fire_fifo_param #(
  parameter int unsigned TAG_W       = 8,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned AF_THRESH   = 6,
  parameter bit          DROP_OLDEST = 1'b0,
  parameter int unsigned CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             asyn_reset,
  input  logic             enq,
  input  logic             deq,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             clr_err,
  output logic [TAG_W-1:0] out_tag,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [TAG_W-1:0] mem_q [DEPTH];
  logic [TAG_W-1:0] mem_d [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic push, pop, ovf_evt, udf_evt;

  // Flags depend only on registered count, so no enq/deq-to-output path exists.
  assign full        = (count_q == CNT_W'(DEPTH));
  assign empty       = (count_q == '0);
  assign almost_full = (count_q >= CNT_W'(AF_THRESH));
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;
  assign out_tag     = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    ovf_evt = enq && full && !deq;
    udf_evt = deq && empty;
    // A simultaneous deq frees the slot; otherwise only the drop policy lets a full enq in.
    push    = enq && (!full || deq || DROP_OLDEST);
    pop     = (deq && !empty) || (ovf_evt && DROP_OLDEST);
  end

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
    overflow_d  = (overflow_q && !clr_err) || ovf_evt;
    underflow_d = (underflow_q && !clr_err) || udf_evt;
    if (push) begin
      mem_d[wr_ptr_q] = in_tag;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk or negedge asyn_reset) begin
    if (!asyn_reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
